bc_param_ctrl: RTL and testbench

//  Control-plane sequencer for brightness_contrast. Turns mode[7:3] key levels into saturated brightness/contrast values.

---
 rtl/bc_param_ctrl_if.sv | 20 ++
 rtl/bc_param_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_bc_param_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bc_param_ctrl_if.sv
// Key/vsync inputs and committed brightness/contrast outputs of bc_param_ctrl.
// master drives keys and vsync; slave is the sequencer.
interface bc_param_ctrl_if;
  logic [7:0]  mode;
  logic        vs_in;
  logic [11:0] brightness_o;
  logic [11:0] contrast_o;
  logic        param_upd;
  logic        pending;

  modport master (
    output mode, vs_in,
    input  brightness_o, contrast_o, param_upd, pending
  );

  modport slave (
    input  mode, vs_in,
    output brightness_o, contrast_o, param_upd, pending
  );
endinterface

// File: rtl/bc_param_ctrl.sv
// Key-driven brightness/contrast sequencer: edits shadow registers with
// saturating steps and auto-repeat, commits them only on a frame start.
module bc_param_ctrl #(
  parameter int STEP_S     = 10,
  parameter int STEP_L     = 50,
  parameter int B_MIN      = -255,
  parameter int B_MAX      = 255,
  parameter int C_MAX      = 1023,
  parameter int C_RST      = 256,
  parameter int REPEAT_DLY = 25000000,
  parameter int REPEAT_PER = 5000000,
  parameter int CNT_W      = 25
) (
  input  logic            axi_clk,
  input  logic            rst,
  bc_param_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_e;

  localparam logic [CNT_W-1:0]   DLY_M1  = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0]   PER_M1  = CNT_W'(REPEAT_PER - 1);
  localparam logic signed [12:0] STEP_S13 = 13'(STEP_S);
  localparam logic signed [12:0] STEP_L13 = 13'(STEP_L);
  localparam logic signed [12:0] B_MIN13  = 13'(B_MIN);
  localparam logic signed [12:0] B_MAX13  = 13'(B_MAX);
  localparam logic signed [12:0] C_MAX13  = 13'(C_MAX);

  // ---------------- input synchronisers ----------------
  // key bit i corresponds to mode[4+i]
  logic [3:0] key_s1_q, key_s1_d, key_s2_q, key_s2_d, key_s3_q, key_s3_d;
  logic       vs_s1_q, vs_s1_d, vs_s2_q, vs_s2_d, vs_s3_q, vs_s3_d;
  logic       sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
  logic [3:0] press;
  logic       vs_rise;
  logic       unused_mode;

  assign unused_mode = ^bus.mode[2:0];

  always_comb begin
    key_s1_d = bus.mode[7:4];
    key_s2_d = key_s1_q;
    key_s3_d = key_s2_q;
    vs_s1_d  = bus.vs_in;
    vs_s2_d  = vs_s1_q;
    vs_s3_d  = vs_s2_q;
    sel_s1_d = bus.mode[3];
    sel_s2_d = sel_s1_q;
  end

  assign press   = key_s2_q & ~key_s3_q;
  assign vs_rise = vs_s2_q & ~vs_s3_q;

  // lowest index wins: mode[4] > mode[5] > mode[6] > mode[7]
  logic [1:0] pkey;
  logic       any_press;
  always_comb begin
    pkey = 2'd3;
    if      (press[0]) pkey = 2'd0;
    else if (press[1]) pkey = 2'd1;
    else if (press[2]) pkey = 2'd2;
  end
  assign any_press = |press;

  // ---------------- FSM ----------------
  state_e           state_q, state_d;
  logic [1:0]       key_q, key_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold;
  logic             apply;
  logic [1:0]       akey;
  logic             asel;

  assign hold = key_s2_q[key_q];

  always_ff @(posedge axi_clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_press) state_d = DELAY;
      DELAY:   if (!hold) state_d = IDLE;
               else if (cnt_q == DLY_M1) state_d = REPEAT;
      REPEAT:  if (!hold) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    apply = 1'b0;
    akey  = key_q;
    asel  = sel_q;
    key_d = key_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_press) begin
          apply = 1'b1;
          akey  = pkey;
          asel  = sel_s2_q;
          key_d = pkey;
          sel_d = sel_s2_q;
          cnt_d = '0;
        end
      end
      DELAY: begin
        if (!hold)                cnt_d = '0;
        else if (cnt_q == DLY_M1) begin apply = 1'b1; cnt_d = '0; end
        else                      cnt_d = cnt_q + 1'b1;
      end
      REPEAT: begin
        if (!hold)                cnt_d = '0;
        else if (cnt_q == PER_M1) begin apply = 1'b1; cnt_d = '0; end
        else                      cnt_d = cnt_q + 1'b1;
      end
      default: cnt_d = '0;
    endcase
  end

  // ---------------- shadow datapath ----------------
  logic [11:0]        b_sh_q, b_sh_d, c_sh_q, c_sh_d;
  logic [11:0]        b_out_q, b_out_d, c_out_q, c_out_d;
  logic               upd_q, upd_d, pend_q, pend_d;
  logic signed [12:0] step, base, sum, lo, hi, clamped;
  logic               changed, commit;

  always_comb begin
    case (akey)
      2'd0:    step = STEP_S13;
      2'd1:    step = -STEP_S13;
      2'd2:    step = STEP_L13;
      default: step = -STEP_L13;
    endcase
    base = asel ? {b_sh_q[11], b_sh_q} : {1'b0, c_sh_q};
    lo   = asel ? B_MIN13 : 13'sd0;
    hi   = asel ? B_MAX13 : C_MAX13;
    sum  = base + step;
    if      (sum < lo) clamped = lo;
    else if (sum > hi) clamped = hi;
    else               clamped = sum;
    changed = apply && (clamped != base);
  end

  // commit always sees the pre-step shadow; a same-cycle edit stays pending
  always_comb begin
    commit  = vs_rise && pend_q;
    b_sh_d  = b_sh_q;
    c_sh_d  = c_sh_q;
    if (changed) begin
      if (asel) b_sh_d = clamped[11:0];
      else      c_sh_d = clamped[11:0];
    end
    pend_d  = changed ? 1'b1 : (commit ? 1'b0 : pend_q);
    b_out_d = commit ? b_sh_q : b_out_q;
    c_out_d = commit ? c_sh_q : c_out_q;
    upd_d   = commit;
  end

  always_ff @(posedge axi_clk) begin
    if (rst) begin
      key_s1_q <= '0; key_s2_q <= '0; key_s3_q <= '0;
      vs_s1_q  <= 1'b0; vs_s2_q <= 1'b0; vs_s3_q <= 1'b0;
      sel_s1_q <= 1'b0; sel_s2_q <= 1'b0;
      key_q    <= '0;
      sel_q    <= 1'b0;
      cnt_q    <= '0;
      b_sh_q   <= '0;
      c_sh_q   <= 12'(C_RST);
      b_out_q  <= '0;
      c_out_q  <= 12'(C_RST);
      upd_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      key_s1_q <= key_s1_d; key_s2_q <= key_s2_d; key_s3_q <= key_s3_d;
      vs_s1_q  <= vs_s1_d;  vs_s2_q  <= vs_s2_d;  vs_s3_q  <= vs_s3_d;
      sel_s1_q <= sel_s1_d; sel_s2_q <= sel_s2_d;
      key_q    <= key_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      b_sh_q   <= b_sh_d;
      c_sh_q   <= c_sh_d;
      b_out_q  <= b_out_d;
      c_out_q  <= c_out_d;
      upd_q    <= upd_d;
      pend_q   <= pend_d;
    end
  end

  assign bus.brightness_o = b_out_q;
  assign bus.contrast_o   = c_out_q;
  assign bus.param_upd    = upd_q;
  assign bus.pending      = pend_q;

endmodule

// File: tb/tb_bc_param_ctrl.sv
// Scoreboard bench for bc_param_ctrl: expected commits are queued when a
// vsync is driven and popped whenever the DUT pulses param_upd.
module tb_bc_param_ctrl;
  logic axi_clk = 1'b0;
  logic rst     = 1'b1;

  bc_param_ctrl_if bus ();

  bc_param_ctrl #(
    .REPEAT_DLY (4),
    .REPEAT_PER (3),
    .CNT_W      (4)
  ) dut (
    .axi_clk (axi_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 axi_clk = ~axi_clk;

  typedef struct { int b; int c; } exp_t;
  exp_t q[$];

  int vec = 0;
  int bad = 0;

  // reference model of shadows / committed values
  int b_sh, c_sh, b_co, c_co;
  bit pend_m;

  function automatic int clampv(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_step(input int k, input bit sel);
    int d, nv;
    d = (k == 0) ? 10 : (k == 1) ? -10 : (k == 2) ? 50 : -50;
    if (sel) begin
      nv = clampv(b_sh + d, -255, 255);
      if (nv != b_sh) begin b_sh = nv; pend_m = 1'b1; end
    end else begin
      nv = clampv(c_sh + d, 0, 1023);
      if (nv != c_sh) begin c_sh = nv; pend_m = 1'b1; end
    end
  endtask

  task automatic model_reset();
    b_sh = 0; c_sh = 256; b_co = 0; c_co = 256; pend_m = 1'b0;
    q.delete();
  endtask

  // scoreboard consumer
  always @(negedge axi_clk) begin
    if (!rst && bus.param_upd) begin
      exp_t e;
      vec++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_upd: brightness=%0d contrast=%0d, no commit expected",
                 $signed(bus.brightness_o), bus.contrast_o);
      end else begin
        e = q.pop_front();
        if (int'($signed(bus.brightness_o)) !== e.b || int'(bus.contrast_o) !== e.c) begin
          bad++;
          $display("FAIL commit_value: got b=%0d c=%0d, expected b=%0d c=%0d",
                   $signed(bus.brightness_o), bus.contrast_o, e.b, e.c);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge axi_clk);
    #1;
  endtask

  task automatic do_reset();
    bus.mode  = '0;
    bus.vs_in = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
  endtask

  // one-cycle pulse on the keys in mask; the highest-priority one is modelled
  task automatic press_keys(input logic [3:0] mask);
    int k;
    k = mask[0] ? 0 : mask[1] ? 1 : mask[2] ? 2 : 3;
    @(posedge axi_clk); #1;
    bus.mode[7:4] = mask;
    @(posedge axi_clk); #1;
    bus.mode[7:4] = 4'b0;
    model_step(k, bus.mode[3]);
    tick(5);
  endtask

  task automatic check_state(input string nm);
    vec++;
    if (int'($signed(bus.brightness_o)) !== b_co || int'(bus.contrast_o) !== c_co ||
        bus.pending !== pend_m) begin
      bad++;
      $display("FAIL %s: got b=%0d c=%0d pend=%0b, expected b=%0d c=%0d pend=%0b", nm,
               $signed(bus.brightness_o), bus.contrast_o, bus.pending, b_co, c_co, pend_m);
    end
  endtask

  // vsync pulse; with_key raises mode[4] on the same sample edge
  task automatic vs_pulse(input string nm, input bit with_key);
    int exp_n, got_n;
    exp_n = pend_m ? 1 : 0;
    if (pend_m) begin
      q.push_back('{b_sh, c_sh});
      b_co = b_sh; c_co = c_sh; pend_m = 1'b0;
    end
    if (with_key) model_step(0, bus.mode[3]);
    got_n = 0;
    @(posedge axi_clk); #1;
    bus.vs_in = 1'b1;
    if (with_key) bus.mode[4] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge axi_clk);
      if (bus.param_upd) got_n++;
      if (i == 1) bus.mode[4] = 1'b0;
      if (i == 3) bus.vs_in = 1'b0;
    end
    vec++;
    if (got_n !== exp_n) begin
      bad++;
      $display("FAIL %s_upd_count: got %0d pulses, expected %0d", nm, got_n, exp_n);
    end
    check_state(nm);
  endtask

  task automatic test_reset();
    do_reset();
    tick(10);
    @(negedge axi_clk);
    vec++; if (bus.brightness_o !== 12'd0)   begin bad++; $display("FAIL rst_brightness: got %0d expected 0", bus.brightness_o); end
    vec++; if (bus.contrast_o   !== 12'd256) begin bad++; $display("FAIL rst_contrast: got %0d expected 256", bus.contrast_o); end
    vec++; if (bus.param_upd    !== 1'b0)    begin bad++; $display("FAIL rst_upd: got %0b expected 0", bus.param_upd); end
    vec++; if (bus.pending      !== 1'b0)    begin bad++; $display("FAIL rst_pending: got %0b expected 0", bus.pending); end
  endtask

  task automatic test_small_step();
    do_reset();
    bus.mode[3] = 1'b1;
    tick(4);
    bus.mode[4] = 1'b1;
    @(posedge axi_clk); #1;            // edge N samples the key
    bus.mode[4] = 1'b0;
    @(posedge axi_clk);                // edge N+1: press asserted
    @(negedge axi_clk);
    vec++; if (bus.pending !== 1'b0) begin bad++; $display("FAIL step_pend_n1: got %0b expected 0", bus.pending); end
    @(posedge axi_clk);                // edge N+2: shadow updated
    @(negedge axi_clk);
    vec++; if (bus.pending !== 1'b1) begin bad++; $display("FAIL step_pend_n2: got %0b expected 1", bus.pending); end
    model_step(0, 1'b1);
    tick(4);
    vs_pulse("small_step", 1'b0);
  endtask

  task automatic test_clamp();
    do_reset();
    bus.mode[3] = 1'b1;
    tick(4);
    for (int i = 0; i < 6; i++) press_keys(4'b1000);
    vs_pulse("clamp_low", 1'b0);
    vec++; if (int'($signed(bus.brightness_o)) !== -255) begin bad++; $display("FAIL clamp_value: got %0d expected -255", $signed(bus.brightness_o)); end
    press_keys(4'b1000);
    @(negedge axi_clk);
    vec++; if (bus.pending !== 1'b0) begin bad++; $display("FAIL clamp_noop_pending: got %0b expected 0", bus.pending); end
  endtask

  task automatic test_repeat();
    do_reset();
    bus.mode[3] = 1'b0;
    tick(4);
    bus.mode[6] = 1'b1;
    repeat (12) @(posedge axi_clk);
    #1;
    bus.mode[6] = 1'b0;
    // initial press, one after the delay, two more repeats while held
    for (int i = 0; i < 4; i++) model_step(2, 1'b0);
    tick(10);
    check_state("repeat_pending");
    vs_pulse("repeat", 1'b0);
    vec++; if (bus.contrast_o !== 12'd456) begin bad++; $display("FAIL repeat_value: got %0d expected 456", bus.contrast_o); end
    tick(20);
    check_state("repeat_released");
  endtask

  task automatic test_priority();
    do_reset();
    bus.mode[3] = 1'b1;
    tick(4);
    press_keys(4'b0011);
    vs_pulse("priority", 1'b0);
    vec++; if (int'($signed(bus.brightness_o)) !== 10) begin bad++; $display("FAIL priority_value: got %0d expected 10", $signed(bus.brightness_o)); end
  endtask

  task automatic test_coincide();
    do_reset();
    bus.mode[3] = 1'b1;
    tick(4);
    press_keys(4'b0001);               // shadow 10, pending
    vs_pulse("coincide", 1'b1);        // commits 10, shadow becomes 20
    vs_pulse("coincide_next", 1'b0);   // commits 20
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.mode[3] = 1'b1;
    tick(4);
    press_keys(4'b0001);
    vs_pulse("mid_setup", 1'b0);
    @(posedge axi_clk); #1;
    bus.mode[4] = 1'b1;
    tick(12);                          // into REPEAT with several edits pending
    vec++; if (bus.pending !== 1'b1) begin bad++; $display("FAIL mid_pending: got %0b expected 1", bus.pending); end
    rst = 1'b1;
    bus.mode[4] = 1'b0;
    @(posedge axi_clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge axi_clk);
    vec++; if (bus.param_upd !== 1'b0) begin bad++; $display("FAIL mid_upd: got %0b expected 0", bus.param_upd); end
    check_state("mid_reset");
    tick(5);
    vs_pulse("mid_vs", 1'b0);
  endtask

  initial begin
    bus.mode  = '0;
    bus.vs_in = 1'b0;
    model_reset();
    test_reset();
    test_small_step();
    test_clamp();
    test_repeat();
    test_priority();
    test_coincide();
    test_reset_mid();
    tick(5);
    vec++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d commits never seen, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
